// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one SPI master among N_REQ requesters.
// It grants one requester at a time, launches the byte transfer and returns the result with a timeout.
module spi_req_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned DW      = 8,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                  spi_clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*DW-1:0]   req_data,
   output logic [N_REQ-1:0]      grant,
   output logic [N_REQ-1:0]      ack,
   output logic [DW-1:0]         rx_data,
   output logic                  err,
   output logic                  arb_busy,
   output logic                  m_start,
   output logic [DW-1:0]         m_tx_data,
   input  logic                  m_busy,
   input  logic                  m_valid,
   input  logic [DW-1:0]         m_rx_data
);

   localparam int unsigned LW = $clog2(N_REQ);
   localparam int unsigned SW = LW + 1;
   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StLaunch, StWaitDone, StResp} state_e;

   state_e           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [LW-1:0]    gidx_q, gidx_d;
   logic [LW-1:0]    last_q, last_d;
   logic [DW-1:0]    tx_q, tx_d;
   logic [DW-1:0]    rx_q, rx_d;
   logic             err_q, err_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             win_found;
   logic [LW-1:0]    win_idx;
   logic [DW-1:0]    req_bytes [N_REQ];

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_bytes[i] = req_data[i*DW +: DW];
      end
   end

   // Search upward from last+1, wrapping modulo N_REQ.
   always_comb begin : rr_search
      logic [SW-1:0] sum;
      sum       = '0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         sum = {1'b0, last_q} + SW'(i);
         if (sum >= SW'(N_REQ)) begin
            sum = sum - SW'(N_REQ);
         end
         if (!win_found && req[sum[LW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = sum[LW-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (win_found && !m_busy) begin
               grant_d = N_REQ'(1) << win_idx;
               gidx_d  = win_idx;
               tx_d    = req_bytes[win_idx];
               state_d = StLaunch;
            end
         end
         StLaunch: begin
            cnt_d   = '0;
            state_d = StWaitDone;
         end
         StWaitDone: begin
            // A completion on the timeout cycle still counts as success.
            if (m_valid) begin
               rx_d    = m_rx_data;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rx_d    = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            last_d  = gidx_q;
            grant_d = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge spi_clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= LW'(N_REQ - 1);
         tx_q    <= '0;
         rx_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant     = grant_q;
   assign ack       = (state_q == StResp) ? grant_q : '0;
   assign rx_data   = rx_q;
   assign err       = (state_q == StResp) && err_q;
   assign arb_busy  = (state_q != StIdle);
   assign m_start   = (state_q == StLaunch);
   assign m_tx_data = tx_q;

endmodule
